// File: rtl/core_pkg.sv
// Shared core definitions: exception codes, EX/MEM occupancy states and the
// EX/MEM pipeline entry layout.
package core_pkg;

  // Arithmetic overflow exception code
  localparam logic [4:0] EXC_OV = 5'h0C;

  // Occupancy of the two-entry EX/MEM buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // One EX/MEM pipeline entry
  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] result;
  } ex_mem_entry_t;

  localparam int ENTRY_W = $bits(ex_mem_entry_t);

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry in-order skid buffer. The head entry is held in its own register,
// so downstream sees registered data. The caller never pushes when the buffer
// is full and never pops when it is empty.
module pipe_skid_buffer
  import core_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output occ_state_e   o_state,
  output occ_state_e   o_state_d
);

  occ_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  // Next occupancy and slot contents from push/pop; clear empties the buffer
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OCC_EMPTY: begin
        if (i_push) begin
          head_d  = i_data;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (i_push && i_pop) begin
          head_d  = i_data;
          state_d = OCC_ONE;
        end else if (i_push) begin
          tail_d  = i_data;
          state_d = OCC_TWO;
        end else if (i_pop) begin
          state_d = OCC_EMPTY;
        end else begin
          state_d = OCC_ONE;
        end
      end
      OCC_TWO: begin
        if (i_pop) begin
          head_d  = tail_q;
          state_d = OCC_ONE;
        end else begin
          state_d = OCC_TWO;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
    if (i_clr) begin
      state_d = OCC_EMPTY;
    end else begin
      state_d = state_d;
    end
  end

  // Storage and occupancy registers; reset clears the data as well
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign o_head    = head_q;
  assign o_state   = state_q;
  assign o_state_d = state_d;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register stage with a two-entry buffer, GPR-write
// suppression, overflow exception reporting and a post-overflow hold that
// drops new instructions until the controller flushes.
// Optional feature: define EX_MEM_FWD_EN to add the head-entry forwarding
// outputs o_fwd_valid / o_fwd_rd / o_fwd_data.
module ex_mem_stage
  import core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_overflow,
  input  logic        i_alu_no_write_override,
  input  logic [4:0]  i_rd,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_store_data,
  output logic [31:0] o_pc,
  output logic        o_exc_valid,
  output logic [4:0]  o_exc_code,
`ifdef EX_MEM_FWD_EN
  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd,
  output logic [31:0] o_fwd_data,
`endif
  output logic [31:0] o_epc
);

  logic          ready_q, ready_d;
  logic          hold_q, hold_d;
  logic          push_s, pop_s;
  ex_mem_entry_t entry_in_s;
  ex_mem_entry_t head_s;
  logic [ENTRY_W-1:0] head_bits_s;
  occ_state_e    state_s, state_d_s;

  // While holding after an overflow, offered inputs are accepted but dropped
  assign push_s = i_valid & ready_q & ~i_flush & ~hold_q;
  assign pop_s  = o_valid & i_mem_ready & ~i_flush;

  // Build the stored entry; overflow kills the GPR write and any memory access
  always_comb begin
    entry_in_s            = '0;
    entry_in_s.exc        = i_alu_overflow;
    entry_in_s.pc         = i_pc;
    entry_in_s.store_data = i_store_data;
    entry_in_s.mem_read   = i_mem_read & ~i_alu_overflow;
    entry_in_s.mem_write  = i_mem_write & ~i_alu_overflow;
    entry_in_s.reg_write  = i_reg_write & i_alu_no_write_override & ~i_alu_overflow;
    entry_in_s.rd         = i_rd;
    entry_in_s.result     = i_alu_result;
  end

  pipe_skid_buffer #(
    .W (ENTRY_W)
  ) u_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_push    (push_s),
    .i_pop     (pop_s),
    .i_data    (entry_in_s),
    .o_head    (head_bits_s),
    .o_state   (state_s),
    .o_state_d (state_d_s)
  );

  assign head_s = ex_mem_entry_t'(head_bits_s);

  // Next hold flag and ready; ready stays high while holding so EX never stalls
  always_comb begin
    hold_d  = hold_q | (push_s & i_alu_overflow);
    ready_d = 1'b1;
    if (i_flush) begin
      hold_d = 1'b0;
    end else begin
      hold_d = hold_d;
    end
    if (hold_d) begin
      ready_d = 1'b1;
    end else begin
      ready_d = (state_d_s != OCC_TWO);
    end
  end

  // Hold flag and registered ready
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      hold_q  <= hold_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = (state_s != OCC_EMPTY);
  assign o_result     = head_s.result;
  assign o_rd         = head_s.rd;
  assign o_reg_write  = head_s.reg_write;
  assign o_mem_read   = head_s.mem_read;
  assign o_mem_write  = head_s.mem_write;
  assign o_store_data = head_s.store_data;
  assign o_pc         = head_s.pc;
  assign o_exc_valid  = o_valid & head_s.exc;
  assign o_exc_code   = o_exc_valid ? EXC_OV : 5'h00;
  assign o_epc        = head_s.pc;

`ifdef EX_MEM_FWD_EN
  assign o_fwd_valid = o_valid & head_s.reg_write;
  assign o_fwd_rd    = head_s.rd;
  assign o_fwd_data  = head_s.result;
`endif

endmodule
